pwm_peripheral: RTL and testbench



---
 rtl/pwm_pkg.sv | 23 ++
 rtl/pwm_timebase.sv | 57 +++++
 rtl/pwm_peripheral.sv | 60 ++++++
 tb/tb_pwm_peripheral.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
//------------------------------------------------------------------------------
// Module   : pwm_pkg
// Purpose  : Shared widths, defaults and the PWM level rule for the PWM block.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

package pwm_pkg;

  localparam int              PWM_W               = 8;
  localparam int              PWM_CLK_DIV_DEFAULT = 3000;
  localparam logic [PWM_W-1:0] DUTY_FULL          = 8'hFF;

  // Full-scale duty holds the line high through the 255 -> 0 wrap.
  function automatic logic pwm_level(input logic [PWM_W-1:0] cnt,
                                     input logic [PWM_W-1:0] duty);
    return (duty == DUTY_FULL) || (cnt < duty);
  endfunction

endpackage

`default_nettype wire

// File: rtl/pwm_timebase.sv
//------------------------------------------------------------------------------
// Module   : pwm_timebase
// Purpose  : Clock prescaler, 8-bit PWM period counter and duty-cycle shadow.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module pwm_timebase
  import pwm_pkg::*;
#(
  parameter int CLK_DIV = PWM_CLK_DIV_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [PWM_W-1:0] pwm_duty_cycle,
  output logic [PWM_W-1:0] pwm_cnt,
  output logic [PWM_W-1:0] duty_q,
  output logic             period_start
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] r_div_cnt;
  logic [PWM_W-1:0] r_pwm_cnt;
  logic [PWM_W-1:0] r_duty_q;
  logic             w_tick;
  logic             w_period_start;

  // With CLK_DIV == 1 the divider stays at 0 and every cycle is a tick.
  assign w_tick         = (r_div_cnt == DIV_LAST);
  assign w_period_start = w_tick && (r_pwm_cnt == {PWM_W{1'b1}});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div_cnt <= '0;
      r_pwm_cnt <= '0;
      r_duty_q  <= '0;
    end else begin
      r_div_cnt <= w_tick ? '0 : r_div_cnt + 1'b1;
      if (w_tick) begin
        r_pwm_cnt <= r_pwm_cnt + 1'b1;
      end
      if (w_period_start) begin
        r_duty_q <= pwm_duty_cycle;
      end
    end
  end

  assign pwm_cnt      = r_pwm_cnt;
  assign duty_q       = r_duty_q;
  assign period_start = w_period_start;

endmodule

`default_nettype wire

// File: rtl/pwm_peripheral.sv
//------------------------------------------------------------------------------
// Module   : pwm_peripheral
// Purpose  : Drives 16 pins as static off / static on / shared PWM waveform.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module pwm_peripheral
  import pwm_pkg::*;
#(
  parameter int CLK_DIV = PWM_CLK_DIV_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] en_out_uo,
  input  logic [7:0] en_out_uio,
  input  logic [7:0] en_pwm_uo,
  input  logic [7:0] en_pwm_uio,
  input  logic [7:0] pwm_duty_cycle,
  output logic [7:0] out_uo,
  output logic [7:0] out_uio
);

  logic [PWM_W-1:0] w_pwm_cnt;
  logic [PWM_W-1:0] w_duty_q;
  logic             w_pwm_lvl;
  logic [7:0]       w_next_uo;
  logic [7:0]       w_next_uio;

  pwm_timebase #(
    .CLK_DIV        (CLK_DIV)
  ) u_timebase (
    .clk            (clk),
    .rst_n          (rst_n),
    .pwm_duty_cycle (pwm_duty_cycle),
    .pwm_cnt        (w_pwm_cnt),
    .duty_q         (w_duty_q),
    .period_start   ()
  );

  assign w_pwm_lvl = pwm_level(w_pwm_cnt, w_duty_q);

  // Enabled pins show either the PWM level or a constant 1.
  assign w_next_uo  = en_out_uo  & (~en_pwm_uo  | {8{w_pwm_lvl}});
  assign w_next_uio = en_out_uio & (~en_pwm_uio | {8{w_pwm_lvl}});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_uo  <= 8'h00;
      out_uio <= 8'h00;
    end else begin
      out_uo  <= w_next_uo;
      out_uio <= w_next_uio;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pwm_peripheral.sv
//------------------------------------------------------------------------------
// Module   : tb_pwm_peripheral
// Purpose  : Directed bench for pwm_peripheral with an edge-count PWM model.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_pwm_peripheral;

  localparam int CLK_DIV = 4;
  localparam int PERIOD  = 256 * CLK_DIV;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] en_out_uo = 8'hFF, en_out_uio = 8'hFF;
  logic [7:0] en_pwm_uo = 8'hFF, en_pwm_uio = 8'hFF;
  logic [7:0] pwm_duty_cycle = 8'hFF;
  logic [7:0] out_uo, out_uio;

  int n_checks = 0;
  int n_errors = 0;
  bit cmp_en   = 1'b0;

  pwm_peripheral #(.CLK_DIV(CLK_DIV)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .en_out_uo      (en_out_uo),
    .en_out_uio     (en_out_uio),
    .en_pwm_uo      (en_pwm_uo),
    .en_pwm_uio     (en_pwm_uio),
    .pwm_duty_cycle (pwm_duty_cycle),
    .out_uo         (out_uo),
    .out_uio        (out_uio)
  );

  always #5 clk = ~clk;

  // Model: e counts rising edges since reset release; the counter value seen
  // before edge e is ((e-1)/CLK_DIV) mod 256, and the shadow reloads on every
  // edge that is a multiple of one full period.
  int unsigned m_edges = 0;
  logic [7:0]  m_duty  = 8'h00;
  logic [7:0]  exp_uo  = 8'h00;
  logic [7:0]  exp_uio = 8'h00;

  function automatic logic [7:0] f_pins(input int unsigned e, input logic [7:0] duty,
                                        input logic [7:0] en_o, input logic [7:0] en_p);
    int unsigned cnt;
    logic        lvl;
    cnt = ((e - 1) / CLK_DIV) % 256;
    lvl = (duty == 8'hFF) || (cnt < duty);
    return en_o & (~en_p | {8{lvl}});
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_edges <= 0;
      m_duty  <= 8'h00;
      exp_uo  <= 8'h00;
      exp_uio <= 8'h00;
    end else begin
      m_edges <= m_edges + 1;
      exp_uo  <= f_pins(m_edges + 1, m_duty, en_out_uo, en_pwm_uo);
      exp_uio <= f_pins(m_edges + 1, m_duty, en_out_uio, en_pwm_uio);
      if ((m_edges + 1) % PERIOD == 0) m_duty <= pwm_duty_cycle;
    end
  end

  always @(negedge clk) begin
    if (rst_n && cmp_en) begin
      n_checks++;
      if (out_uo !== exp_uo || out_uio !== exp_uio) begin
        n_errors++;
        $display("FAIL model edge=%0d uo got %02h exp %02h uio got %02h exp %02h",
                 m_edges, out_uo, exp_uo, out_uio, exp_uio);
      end
    end
  end

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %02h expected %02h", name, act, req);
    end
  endtask

  task automatic check_int(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  task automatic wait_edge(input int unsigned n);
    while (m_edges < n) @(negedge clk);
  endtask

  initial begin
    #2000000;
    n_errors++;
    $display("FAIL timeout: got no finish expected finish");
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    int hi;
    int bad;

    // Reset held with everything enabled.
    repeat (3) @(negedge clk);
    check8("reset_uo", out_uo, 8'h00);
    check8("reset_uio", out_uio, 8'h00);

    // Release with static drive selected, then switch to PWM.
    en_pwm_uo  = 8'h00;
    en_pwm_uio = 8'h00;
    rst_n  = 1'b1;
    cmp_en = 1'b1;
    @(negedge clk);
    check8("release_uo", out_uo, 8'hFF);
    check8("release_uio", out_uio, 8'hFF);
    en_pwm_uo  = 8'hFF;
    en_pwm_uio = 8'hFF;
    wait_edge(1024);
    check8("pre_boundary_uo", out_uo, 8'h00);
    wait_edge(1025);
    check8("post_boundary_uo", out_uo, 8'hFF);
    check8("post_boundary_uio", out_uio, 8'hFF);

    // Static drive and 1-clock enable latency.
    en_out_uo  = 8'h05;
    en_pwm_uo  = 8'h00;
    en_out_uio = 8'h80;
    en_pwm_uio = 8'h00;
    @(negedge clk);
    check8("static_uo", out_uo, 8'h05);
    check8("static_uio", out_uio, 8'h80);
    en_out_uo = 8'h00;
    @(negedge clk);
    check8("static_clear_uo", out_uo, 8'h00);
    check8("static_hold_uio", out_uio, 8'h80);

    // 50 % duty over one full period.
    pwm_duty_cycle = 8'h80;
    en_out_uo = 8'hFF; en_out_uio = 8'hFF;
    en_pwm_uo = 8'hFF; en_pwm_uio = 8'hFF;
    wait_edge(2048);
    hi = 0;
    for (int k = 0; k < PERIOD; k++) begin
      @(negedge clk);
      if (out_uo == 8'hFF && out_uio == 8'hFF) hi++;
    end
    check_int("duty80_high_clocks", hi, 512);

    // Duty 0 for three periods; request 0xFF mid-period.
    pwm_duty_cycle = 8'h00;
    wait_edge(4096);
    bad = 0;
    for (int k = 0; k < 3 * PERIOD; k++) begin
      @(negedge clk);
      if (m_edges == 7000) pwm_duty_cycle = 8'hFF;
      if (out_uo != 8'h00 || out_uio != 8'h00) bad++;
    end
    check_int("duty00_high_clocks", bad, 0);

    // Duty 0xFF across two periods and the wrap.
    bad = 0;
    for (int k = 0; k < 2 * PERIOD; k++) begin
      @(negedge clk);
      if (m_edges == 9000) pwm_duty_cycle = 8'h40;
      if (out_uo != 8'hFF || out_uio != 8'hFF) bad++;
    end
    check_int("dutyFF_low_clocks", bad, 0);

    // 0x40 period with 0xC0 written at pwm_cnt 0x20.
    hi = 0;
    for (int k = 0; k < PERIOD; k++) begin
      @(negedge clk);
      if (m_edges == 9216 + 32 * CLK_DIV) pwm_duty_cycle = 8'hC0;
      if (out_uo == 8'hFF) hi++;
    end
    check_int("duty40_high_clocks", hi, 256);
    hi = 0;
    for (int k = 0; k < PERIOD; k++) begin
      @(negedge clk);
      if (out_uo == 8'hFF) hi++;
    end
    check_int("dutyC0_high_clocks", hi, 768);

    // Asynchronous reset during the high phase at pwm_cnt 0x10.
    wait_edge(11264 + 16 * CLK_DIV);
    check8("pre_reset_uo", out_uo, 8'hFF);
    #2;
    rst_n = 1'b0;
    #1;
    check8("async_reset_uo", out_uo, 8'h00);
    check8("async_reset_uio", out_uio, 8'h00);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int k = 0; k < PERIOD; k++) begin
      @(negedge clk);
      if (out_uo != 8'h00 || out_uio != 8'h00) bad++;
    end
    check_int("after_reset_high_clocks", bad, 0);
    @(negedge clk);
    check8("after_reset_boundary_uo", out_uo, 8'hFF);
    check8("after_reset_boundary_uio", out_uio, 8'hFF);

    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
